// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-core RAM port arbiter.
// RAM handshake states, arbiter FSM states and request kinds.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    IW = 2'd0,
    DR = 2'd1,
    DW = 2'd2
  } req_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Two-core round-robin pick plus per-core request priority.
// Purely combinational; dcache write beats dcache read beats icache.
module rr_picker
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] ireq,
  input  logic [1:0] drd,
  input  logic [1:0] dwr,
  input  logic       rr,
  output logic       core,
  output req_t       kind,
  output logic       valid
);

  logic [1:0] req;

  assign req   = ireq | drd | dwr;
  assign valid = |req;
  assign core  = (&req) ? rr : req[1];

  always_comb begin
    kind = IW;
    priority case (1'b1)
      dwr[core]: kind = DW;
      drd[core]: kind = DR;
      default:   kind = IW;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between two cores' icache/dcache requests.
// One grant at a time, round-robin across cores, watchdog on hung RAM.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NCORE   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NCORE-1:0]       iREN,
  input  logic [NCORE-1:0]       dREN,
  input  logic [NCORE-1:0]       dWEN,
  input  logic [NCORE-1:0][31:0] iaddr,
  input  logic [NCORE-1:0][31:0] daddr,
  input  logic [NCORE-1:0][31:0] dstore,
  output logic [NCORE-1:0]       iwait,
  output logic [NCORE-1:0]       dwait,
  output logic [NCORE-1:0][31:0] iload,
  output logic [NCORE-1:0][31:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  logic [1:0]             ramstate,
  output logic                   err
);

  arb_state_t state, nstate;
  logic       rr, rr_n;
  logic       win_core;
  req_t       win_type;
  word_t      lat_addr, lat_store;
  logic [31:0] wdog, wdog_n;

  logic pk_core, pk_valid;
  req_t pk_type;
  logic ld, held, access, tmo, illegal;

  rr_picker u_pick (
    .ireq  (iREN),
    .drd   (dREN),
    .dwr   (dWEN),
    .rr    (rr),
    .core  (pk_core),
    .kind  (pk_type),
    .valid (pk_valid)
  );

  assign access  = (ramstate_t'(ramstate) == ACCESS);
  assign illegal = |(dREN & dWEN);

  always_comb begin
    held = 1'b0;
    case (win_type)
      IW:      held = iREN[win_core];
      DR:      held = dREN[win_core];
      DW:      held = dWEN[win_core];
      default: held = 1'b0;
    endcase
  end

  always_comb begin
    nstate   = state;
    rr_n     = rr;
    wdog_n   = wdog;
    ld       = 1'b0;
    tmo      = 1'b0;
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IDLE: begin
        wdog_n = '0;
        if (pk_valid) begin
          nstate = GRANT;
          ld     = 1'b1;
        end
      end
      GRANT: begin
        ramREN   = (win_type != DW);
        ramWEN   = (win_type == DW);
        ramaddr  = lat_addr;
        ramstore = lat_store;
        if (!held) begin
          // requester gave up: quiet return, fairness untouched
          nstate = IDLE;
          wdog_n = '0;
        end else if (access) begin
          nstate = IDLE;
          rr_n   = ~win_core;
          wdog_n = '0;
          case (win_type)
            IW: begin
              iwait[win_core] = 1'b0;
              iload[win_core] = ramload;
            end
            DR: begin
              dwait[win_core] = 1'b0;
              dload[win_core] = ramload;
            end
            default: dwait[win_core] = 1'b0;
          endcase
        end else if ((TIMEOUT > 0) &&
                     (wdog + 32'd1 >= 32'(TIMEOUT))) begin
          nstate = IDLE;
          rr_n   = ~win_core;
          wdog_n = '0;
          tmo    = 1'b1;
        end else begin
          wdog_n = wdog + 32'd1;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      rr        <= 1'b0;
      wdog      <= '0;
      err       <= 1'b0;
      win_core  <= 1'b0;
      win_type  <= IW;
      lat_addr  <= '0;
      lat_store <= '0;
    end else begin
      state <= nstate;
      rr    <= rr_n;
      wdog  <= wdog_n;
      if (ld) begin
        win_core  <= pk_core;
        win_type  <= pk_type;
        lat_addr  <= (pk_type == IW) ? iaddr[pk_core]
                                     : daddr[pk_core];
        lat_store <= dstore[pk_core];
      end
      if (tmo || illegal)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a completion scoreboard.
// Inputs change on falling edges; outputs sampled 1-2 time units later.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       iREN, dREN, dWEN;
  logic [1:0][31:0] iaddr, daddr, dstore;
  logic [1:0]       iwait, dwait;
  logic [1:0][31:0] iload, dload;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;
  logic             err;

  always #5 CLK = ~CLK;

  mem_arbiter #(.NCORE(2), .TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .err(err)
  );

  typedef struct {
    bit          core;
    bit          dside;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit c, input bit d, input logic [31:0] v);
    exp_t e;
    e.core  = c;
    e.dside = d;
    e.data  = v;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input bit c, input bit d, input logic [31:0] v);
    exp_t e;
    total++;
    assert (sbq.size() != 0) else begin
      bad++;
      $error("FAIL sb_unexpected obs=core%0d/d%0d exp=none", c, d);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("sb_core", 32'(c), 32'(e.core));
      chk("sb_side", 32'(d), 32'(e.dside));
      chk("sb_data", v, e.data);
    end
  endtask

  always @(negedge CLK) begin
    #2;
    for (int c = 0; c < 2; c++) begin
      if (iwait[c] === 1'b0) sb_pop(c[0], 1'b0, iload[c]);
      if (dwait[c] === 1'b0) sb_pop(c[0], 1'b1, dload[c]);
    end
    if (iwait === 2'b11 && dwait === 2'b11)
      chk("idle_load", 32'(|{iload, dload}), 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;

    // reset state
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_ren", 32'(ramREN), 0);
    chk("rst_wen", 32'(ramWEN), 0);
    chk("rst_addr", ramaddr, 0);
    chk("rst_store", ramstore, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_wait", 32'({iwait, dwait}), 32'hF);
    nRST = 1'b1;

    // single icache read, two BUSY cycles then ACCESS
    @(negedge CLK);
    iREN[0] = 1'b1; iaddr[0] = 32'h100; ramstate = BUSY;
    repeat (2) begin
      @(negedge CLK); #1;
      chk("t1_ren", 32'(ramREN), 1);
      chk("t1_addr", ramaddr, 32'h100);
      chk("t1_busywait", 32'(iwait), 32'h3);
    end
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    push(1'b0, 1'b0, 32'hDEADBEEF);
    #1;
    chk("t1_donewait", 32'(iwait), 32'h2);
    chk("t1_iload", iload[0], 32'hDEADBEEF);
    chk("t1_acc_addr", ramaddr, 32'h100);
    @(negedge CLK);
    iREN[0] = 1'b0; ramstate = FREE;
    #1;
    chk("t1_idle_ren", 32'(ramREN), 0);

    // core1 write beats its icache read
    @(negedge CLK);
    iREN[1] = 1'b1; iaddr[1] = 32'h200;
    dWEN[1] = 1'b1; daddr[1] = 32'h40; dstore[1] = 32'h12345678;
    @(negedge CLK);
    ramstate = ACCESS;
    push(1'b1, 1'b1, 32'h0);
    #1;
    chk("t2_wen", 32'(ramWEN), 1);
    chk("t2_ren", 32'(ramREN), 0);
    chk("t2_store", ramstore, 32'h12345678);
    chk("t2_addr", ramaddr, 32'h40);
    chk("t2_iwait", 32'(iwait), 32'h3);
    @(negedge CLK);
    dWEN[1] = 1'b0; ramstate = FREE;
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'hCAFE0001;
    push(1'b1, 1'b0, 32'hCAFE0001);
    #1;
    chk("t2_iaddr", ramaddr, 32'h200);
    chk("t2_iren", 32'(ramREN), 1);
    @(negedge CLK);
    iREN[1] = 1'b0; ramstate = FREE;

    // both cores hold dREN: grants alternate
    @(negedge CLK);
    dREN = 2'b11; daddr[0] = 32'h300; daddr[1] = 32'h400;
    ramstate = ACCESS;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      ramload = 32'hA0 + 32'(k);
      push(k[0], 1'b1, 32'hA0 + 32'(k));
      #1;
      chk("t3_addr", ramaddr, k[0] ? 32'h400 : 32'h300);
      chk("t3_dwait", 32'(dwait), k[0] ? 32'h1 : 32'h2);
      @(negedge CLK);
      if (k == 3) begin
        dREN = 2'b00; ramstate = FREE;
      end
      #1;
      chk("t3_gap", 32'(dwait), 32'h3);
    end

    // withdrawal on second GRANT cycle keeps rr at core0
    @(negedge CLK);
    dREN[0] = 1'b1; daddr[0] = 32'h500; ramstate = BUSY;
    @(negedge CLK); #1;
    chk("t4_addr", ramaddr, 32'h500);
    @(negedge CLK);
    dREN[0] = 1'b0;
    #1;
    chk("t4_wd_wait", 32'(dwait), 32'h3);
    @(negedge CLK);
    dREN = 2'b11; daddr[0] = 32'h510; daddr[1] = 32'h410;
    #1;
    chk("t4_idle_ren", 32'(ramREN), 0);
    chk("t4_idle_wait", 32'(dwait), 32'h3);
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'h55;
    push(1'b0, 1'b1, 32'h55);
    #1;
    chk("t4_rr_addr", ramaddr, 32'h510);
    @(negedge CLK);
    dREN = 2'b00; ramstate = FREE;

    // brief reset to put rr back on core0
    @(negedge CLK); nRST = 1'b0;
    @(negedge CLK); nRST = 1'b1;

    // watchdog: RAM stuck in ERROR
    @(negedge CLK);
    iREN[0] = 1'b1; iaddr[0] = 32'h700;
    dREN[1] = 1'b1; daddr[1] = 32'h800;
    ramstate = ERROR;
    repeat (4) begin
      @(negedge CLK); #1;
      chk("t5_addr", ramaddr, 32'h700);
      chk("t5_err_lo", 32'(err), 0);
      chk("t5_wait", 32'({iwait, dwait}), 32'hF);
    end
    @(negedge CLK); #1;
    chk("t5_err_hi", 32'(err), 1);
    chk("t5_idle_ren", 32'(ramREN), 0);
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'h88;
    push(1'b1, 1'b1, 32'h88);
    #1;
    chk("t5_next_addr", ramaddr, 32'h800);
    @(negedge CLK);
    iREN = 2'b00; dREN = 2'b00; ramstate = BUSY;
    #1;
    chk("t5_sticky", 32'(err), 1);

    // reset while a write is granted
    @(negedge CLK);
    dWEN[1] = 1'b1; daddr[1] = 32'h600; dstore[1] = 32'h77;
    @(negedge CLK); #1;
    chk("t6_wen", 32'(ramWEN), 1);
    chk("t6_store", ramstore, 32'h77);
    nRST = 1'b0;
    @(negedge CLK); #1;
    chk("t6_wen_rst", 32'(ramWEN), 0);
    chk("t6_addr_rst", ramaddr, 0);
    chk("t6_err_rst", 32'(err), 0);
    chk("t6_wait_rst", 32'({iwait, dwait}), 32'hF);
    @(negedge CLK); #1;
    chk("t6_hold_rst", 32'(ramWEN), 0);
    dWEN[1] = 1'b0; nRST = 1'b1;

    // dREN and dWEN together: write wins, err set
    @(negedge CLK);
    dREN[0] = 1'b1; dWEN[0] = 1'b1;
    daddr[0] = 32'h900; dstore[0] = 32'h99;
    ramstate = ACCESS;
    @(negedge CLK);
    push(1'b0, 1'b1, 32'h0);
    #1;
    chk("t7_wen", 32'(ramWEN), 1);
    chk("t7_ren", 32'(ramREN), 0);
    chk("t7_store", ramstore, 32'h99);
    chk("t7_err", 32'(err), 1);
    @(negedge CLK);
    dREN = 2'b00; dWEN = 2'b00; ramstate = FREE;
    @(negedge CLK); #3;
    chk("sb_drain", 32'(sbq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
